// File: rtl/img_cmd_controller_pkg.sv
// Shared command bytes, status codes and controller state encoding.
// CLEAR has no status code of its own and reports as IDLE.
package img_ctrl_pkg;

    localparam logic [7:0] CMD_IMG   = 8'hFE;
    localparam logic [7:0] CMD_CLEAR = 8'hFD;
    localparam logic [7:0] CMD_READ  = 8'hFC;

    typedef enum logic [3:0] {
        STAT_IDLE       = 4'd0,
        STAT_RX_RDY     = 4'd1,
        STAT_RX_IMG     = 4'd2,
        STAT_BNN_BUSY   = 4'd4,
        STAT_RESULT_RDY = 4'd8,
        STAT_ERROR      = 4'd14
    } status_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IMG,
        ST_IMG_RX,
        ST_BNN_BUSY,
        ST_RESULT_RDY,
        ST_CLEAR,
        ST_ERROR
    } state_e;

    function automatic status_e status_of(input state_e s);
        status_e r;
        case (s)
            ST_WAIT_IMG:   r = STAT_RX_RDY;
            ST_IMG_RX:     r = STAT_RX_IMG;
            ST_BNN_BUSY:   r = STAT_BNN_BUSY;
            ST_RESULT_RDY: r = STAT_RESULT_RDY;
            ST_ERROR:      r = STAT_ERROR;
            default:       r = STAT_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/img_cmd_controller_if.sv
// Controller-side bundle: SPI byte receiver, reply path, image buffer and BNN handshakes.
// master = controller, slave = surrounding datapath.
interface img_cmd_controller_if #(
    parameter int ADDR_W   = 7,
    parameter int RESULT_W = 4
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_enable;
    logic                byte_taken;
    logic [7:0]          tx_data;
    logic                tx_load;
    logic [3:0]          status_code;
    logic                clear;
    logic                buf_wr_req;
    logic                buf_wr_ready;
    logic [7:0]          buf_wr_data;
    logic [ADDR_W-1:0]   buf_wr_addr;
    logic                buf_empty;
    logic                bnn_start;
    logic                bnn_result_valid;
    logic [RESULT_W-1:0] bnn_result;

    modport master (
        input  rx_data, rx_valid, buf_wr_ready, buf_empty, bnn_result_valid, bnn_result,
        output rx_enable, byte_taken, tx_data, tx_load, status_code, clear,
               buf_wr_req, buf_wr_data, buf_wr_addr, bnn_start
    );

    modport slave (
        output rx_data, rx_valid, buf_wr_ready, buf_empty, bnn_result_valid, bnn_result,
        input  rx_enable, byte_taken, tx_data, tx_load, status_code, clear,
               buf_wr_req, buf_wr_data, buf_wr_addr, bnn_start
    );
endinterface

// File: rtl/img_cmd_controller_timeout.sv
// Inter-byte watchdog: counts idle cycles while running, restarts on each byte, saturates at TIMEOUT_CYC.
// Only compiled when IMG_CTRL_TIMEOUT_EN is defined.
`ifdef IMG_CTRL_TIMEOUT_EN
module img_ctrl_timeout #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run || restart) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = run && (cnt_q == LIMIT);
endmodule
`endif

// File: rtl/img_cmd_controller.sv
// SPI command FSM: image capture into a byte buffer, BNN kick-off, result readback and buffer clear.
// Writes/strobes are registered (1 cycle after the byte); a stalled write is held one deep. Timeout needs IMG_CTRL_TIMEOUT_EN.
module img_cmd_controller
    import img_ctrl_pkg::*;
#(
    parameter int IMG_BYTES   = 98,
    parameter int ADDR_W      = $clog2(IMG_BYTES),
    parameter int RESULT_W    = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input logic                 clk,
    input logic                 rst,
    img_cmd_controller_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);

    if (RESULT_W > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("img_cmd_controller: RESULT_W must be <= 8 and TIMEOUT_CYC >= 1");
    end

    state_e              state_q, state_d;
    status_e             status_q, status_d;
    logic                rx_valid_q;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                pend_vld_q, pend_vld_d;
    logic [7:0]          pend_dat_q, pend_dat_d;
    logic                wr_req_q, wr_req_d;
    logic [7:0]          wr_dat_q, wr_dat_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                taken_q, taken_d;
    logic                tx_load_q, tx_load_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                bnn_start_q, bnn_start_d;
    logic                new_byte, wr_go, timeout_hit;
    logic [7:0]          wr_byte;

    assign new_byte = bus.rx_valid && !rx_valid_q;

`ifdef IMG_CTRL_TIMEOUT_EN
    img_ctrl_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .run     (state_q == ST_WAIT_IMG || state_q == ST_IMG_RX),
        .restart (new_byte),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        status_d    = status_of(state_q);
        cnt_d       = cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_dat_d  = pend_dat_q;
        wr_req_d    = 1'b0;
        wr_dat_d    = wr_dat_q;
        wr_addr_d   = wr_addr_q;
        taken_d     = 1'b0;
        tx_load_d   = 1'b0;
        tx_data_d   = tx_data_q;
        result_d    = result_q;
        bnn_start_d = 1'b0;
        wr_go       = 1'b0;
        wr_byte     = bus.rx_data;

        case (state_q)
            ST_IDLE: begin
                if (new_byte) begin
                    taken_d = 1'b1;
                    if (bus.rx_data == CMD_IMG) begin
                        state_d = ST_WAIT_IMG;
                        cnt_d   = '0;
                    end else if (bus.rx_data == CMD_CLEAR) begin
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_WAIT_IMG, ST_IMG_RX: begin
                // 0xFD is only a command before the first image byte; afterwards it is pixel data.
                if (new_byte && state_q == ST_WAIT_IMG && bus.rx_data == CMD_CLEAR) begin
                    taken_d = 1'b1;
                    state_d = ST_CLEAR;
                end else if (new_byte && pend_vld_q) begin
                    taken_d    = 1'b1;
                    pend_vld_d = 1'b0;
                    state_d    = ST_ERROR;
                end else if (new_byte) begin
                    state_d = ST_IMG_RX;
                    if (bus.buf_wr_ready) begin
                        wr_go = 1'b1;
                    end else begin
                        pend_vld_d = 1'b1;
                        pend_dat_d = bus.rx_data;
                    end
                end else if (pend_vld_q && bus.buf_wr_ready) begin
                    wr_go      = 1'b1;
                    wr_byte    = pend_dat_q;
                    pend_vld_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                end
            end
            ST_BNN_BUSY: begin
                if (new_byte) taken_d = 1'b1;
                if (new_byte && bus.rx_data == CMD_CLEAR) begin
                    state_d = ST_CLEAR;
                end else if (bus.bnn_result_valid) begin
                    result_d = bus.bnn_result;
                    state_d  = ST_RESULT_RDY;
                end
            end
            ST_RESULT_RDY: begin
                if (new_byte) begin
                    taken_d = 1'b1;
                    if (bus.rx_data == CMD_READ) begin
                        tx_data_d = 8'(result_q);
                        tx_load_d = 1'b1;
                    end else if (bus.rx_data == CMD_CLEAR) begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_ERROR: begin
                if (new_byte) begin
                    taken_d = 1'b1;
                    if (bus.rx_data == CMD_CLEAR) state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (bus.buf_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_go) begin
            wr_req_d  = 1'b1;
            wr_dat_d  = wr_byte;
            wr_addr_d = cnt_q;
            taken_d   = 1'b1;
            // The last address is never incremented past, so the counter cannot wrap.
            if (cnt_q == LAST_ADDR) state_d = ST_BNN_BUSY;
            else                    cnt_d   = cnt_q + ADDR_W'(1);
        end

        if (state_q == ST_BNN_BUSY && state_d != ST_CLEAR && wr_req_q && wr_addr_q == LAST_ADDR) begin
            bnn_start_d = 1'b1;
        end

        if (state_d == ST_CLEAR && state_q != ST_CLEAR) begin
            cnt_d      = '0;
            wr_addr_d  = '0;
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            status_q    <= STAT_IDLE;
            rx_valid_q  <= 1'b0;
            cnt_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_dat_q  <= '0;
            wr_req_q    <= 1'b0;
            wr_dat_q    <= '0;
            wr_addr_q   <= '0;
            taken_q     <= 1'b0;
            tx_load_q   <= 1'b0;
            tx_data_q   <= '0;
            result_q    <= '0;
            bnn_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            rx_valid_q  <= bus.rx_valid;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_dat_q  <= pend_dat_d;
            wr_req_q    <= wr_req_d;
            wr_dat_q    <= wr_dat_d;
            wr_addr_q   <= wr_addr_d;
            taken_q     <= taken_d;
            tx_load_q   <= tx_load_d;
            tx_data_q   <= tx_data_d;
            result_q    <= result_d;
            bnn_start_q <= bnn_start_d;
        end
    end

    assign bus.rx_enable   = (state_q != ST_CLEAR);
    assign bus.byte_taken  = taken_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_load     = tx_load_q;
    assign bus.status_code = status_q;
    assign bus.clear       = (state_q == ST_CLEAR);
    assign bus.buf_wr_req  = wr_req_q;
    assign bus.buf_wr_data = wr_dat_q;
    assign bus.buf_wr_addr = wr_addr_q;
    assign bus.bnn_start   = bnn_start_q;
endmodule

// File: tb/tb_img_cmd_controller.sv
// Scoreboard bench for img_cmd_controller: stimulus pushes expected writes/status/replies, a negedge monitor pops them.
module tb_img_cmd_controller;
    import img_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    img_cmd_controller_if #(.ADDR_W(7), .RESULT_W(4)) bus ();

    img_cmd_controller #(
        .IMG_BYTES(98), .ADDR_W(7), .RESULT_W(4), .TIMEOUT_CYC(100)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   exp_wr[$];
    int   exp_status[$];
    int   exp_tx[$];
    int   exp_starts = 0;
    logic mon_en = 1'b0;
    logic [3:0] prev_status = 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got 0x%0h, expected no event", name, act);
    endtask

    // Monitor: every DUT-presented event must match the head of its expectation queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.buf_wr_req) begin
                if (exp_wr.size() == 0) unexpected("unexpected_wr", {bus.buf_wr_addr, bus.buf_wr_data});
                else check("wr_addr_data", 32'({bus.buf_wr_addr, bus.buf_wr_data}), 32'(exp_wr.pop_front()));
            end
            if (bus.bnn_start) begin
                if (exp_starts == 0) unexpected("unexpected_bnn_start", 32'(bus.buf_wr_addr));
                else begin
                    exp_starts--;
                    check("start_after_last_wr", 32'(exp_wr.size()), 32'd0);
                end
            end
            if (bus.tx_load) begin
                if (exp_tx.size() == 0) unexpected("unexpected_tx_load", 32'(bus.tx_data));
                else check("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
            end
            if (bus.status_code !== prev_status) begin
                if (exp_status.size() == 0) unexpected("unexpected_status", 32'(bus.status_code));
                else check("status_code", 32'(bus.status_code), 32'(exp_status.pop_front()));
                prev_status = bus.status_code;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_img(input int first, input int count, input int dbase, input bit last_frame_byte);
        for (int i = 0; i < count; i++) begin
            exp_wr.push_back(((first + i) << 8) | ((dbase + i) & 8'hFF));
            if (last_frame_byte && i == count - 1) begin
                exp_starts++;
                exp_status.push_back(STAT_BNN_BUSY);
            end
            send_byte(8'(dbase + i));
        end
    endtask

    task automatic clear_wait();
        repeat (3) begin
            @(negedge clk);
            check("clear_held", 32'(bus.clear), 32'd1);
            check("rx_enable_in_clear", 32'(bus.rx_enable), 32'd0);
        end
        @(posedge clk); #1 bus.buf_empty = 1'b1;
        @(posedge clk); #1 bus.buf_empty = 1'b0;
        @(negedge clk);
        check("clear_released", 32'(bus.clear), 32'd0);
        check("rx_enable_idle", 32'(bus.rx_enable), 32'd1);
    endtask

    task automatic do_clear();
        send_byte(CMD_CLEAR);
        clear_wait();
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_addr", 32'(bus.buf_wr_addr), 32'd0);
        check("rst_status", 32'(bus.status_code), 32'd0);
        check("rst_clear", 32'(bus.clear), 32'd0);
        check("rst_bnn_start", 32'(bus.bnn_start), 32'd0);
    endtask

    task automatic full_frame();
        exp_status.push_back(STAT_RX_RDY);
        send_byte(CMD_IMG);
        exp_status.push_back(STAT_RX_IMG);
        send_img(0, 98, 0, 1'b1);
        idle(3);
    endtask

    initial begin
        bus.rx_data          = 8'h00;
        bus.rx_valid         = 1'b0;
        bus.buf_wr_ready     = 1'b1;
        bus.buf_empty        = 1'b0;
        bus.bnn_result_valid = 1'b0;
        bus.bnn_result       = 4'd0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_status", 32'(bus.status_code), 32'd0);
        check("rst_rx_enable", 32'(bus.rx_enable), 32'd1);
        check("rst_wr_req", 32'(bus.buf_wr_req), 32'd0);
        check("rst_addr", 32'(bus.buf_wr_addr), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_clear", 32'(bus.clear), 32'd0);
        prev_status = 4'd0;
        mon_en = 1'b1;

        // Full frame, then a stray byte in BNN_BUSY, result 7 and readback.
        full_frame();
        send_byte(8'h33);
        exp_status.push_back(STAT_RESULT_RDY);
        @(posedge clk); #1 bus.bnn_result_valid = 1'b1; bus.bnn_result = 4'd7;
        @(posedge clk); #1 bus.bnn_result_valid = 1'b0; bus.bnn_result = 4'd0;
        send_byte(8'h10);
        exp_tx.push_back(8'h07);
        send_byte(CMD_READ);
        idle(2);
        check("status_after_read", 32'(bus.status_code), 32'(STAT_RESULT_RDY));
        exp_status.push_back(STAT_IDLE);
        do_clear();

        // Bad command -> ERROR, sticky against 0xFE, left only by clear.
        exp_status.push_back(STAT_ERROR);
        send_byte(8'h55);
        send_byte(CMD_IMG);
        exp_status.push_back(STAT_IDLE);
        do_clear();

        // Clear straight from WAIT_IMG.
        exp_status.push_back(STAT_RX_RDY);
        send_byte(CMD_IMG);
        exp_status.push_back(STAT_IDLE);
        do_clear();

        // Buffer stall on byte 10, then overrun during a second stall.
        exp_status.push_back(STAT_RX_RDY);
        send_byte(CMD_IMG);
        exp_status.push_back(STAT_RX_IMG);
        send_img(0, 10, 8'h80, 1'b0);
        bus.buf_wr_ready = 1'b0;
        exp_wr.push_back((10 << 8) | 8'h8A);
        send_byte(8'h8A);
        repeat (3) begin
            @(negedge clk);
            check("no_wr_during_stall", 32'(bus.buf_wr_req), 32'd0);
        end
        @(posedge clk); #1 bus.buf_wr_ready = 1'b1;
        idle(3);
        bus.buf_wr_ready = 1'b0;
        send_byte(8'h8B);
        exp_status.push_back(STAT_ERROR);
        send_byte(8'h8C);
        bus.buf_wr_ready = 1'b1;
        idle(4);
        exp_status.push_back(STAT_IDLE);
        do_clear();

        // Clear and result strobe in the same cycle: clear wins, result ignored.
        full_frame();
        exp_status.push_back(STAT_IDLE);
        @(posedge clk); #1;
        bus.rx_data = CMD_CLEAR; bus.rx_valid = 1'b1;
        bus.bnn_result_valid = 1'b1; bus.bnn_result = 4'd5;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0; bus.bnn_result_valid = 1'b0;
        clear_wait();

        // Reset mid-frame abandons the frame.
        exp_status.push_back(STAT_RX_RDY);
        send_byte(CMD_IMG);
        exp_status.push_back(STAT_RX_IMG);
        send_img(0, 4, 8'h40, 1'b0);
        idle(2);
        exp_status.push_back(STAT_IDLE);
        pulse_reset();

        // New frame restarts at address 0, then stalls past the timeout.
        exp_status.push_back(STAT_RX_RDY);
        send_byte(CMD_IMG);
        exp_status.push_back(STAT_RX_IMG);
        send_img(0, 6, 8'hA0, 1'b0);
`ifdef IMG_CTRL_TIMEOUT_EN
        exp_status.push_back(STAT_ERROR);
        idle(120);
        check("status_timeout", 32'(bus.status_code), 32'(STAT_ERROR));
        exp_status.push_back(STAT_IDLE);
        do_clear();
`else
        idle(120);
        check("status_no_timeout", 32'(bus.status_code), 32'(STAT_RX_IMG));
        exp_status.push_back(STAT_IDLE);
        pulse_reset();
`endif

        idle(5);
        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        check("status_queue_drained", 32'(exp_status.size()), 32'd0);
        check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        check("bnn_start_count", 32'(exp_starts), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
